// File: rtl/anton_neopixel_decoder.sv
// NeoPixel (WS2812) line receiver: oversamples the data line, classifies each bit by
// its high-pulse width, assembles MSB-first bytes and flags the latch gap.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 15
`endif

module anton_neopixel_decoder #(
    parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
    parameter int HIGH_MIN     = 2,
    parameter int HIGH_ONE_MIN = 4,
    parameter int HIGH_MAX     = 6,
    parameter int RESET_LOW    = 320,
    localparam int BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1
) (
    input  logic                   clk6_4mhz,
    input  logic                   syncReset,
    input  logic                   neoDataIn,
    input  logic                   enable,
    output logic [7:0]             dataByte,
    output logic                   dataValid,
    output logic [BUFFER_BITS-1:0] byteIndex,
    output logic                   frameDone,
    output logic                   decodeError,
    output logic                   overflow
);
    localparam int CNT_W = $clog2(RESET_LOW + 1);
    localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_MAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]       RESET_LOW_C  = CNT_W'(RESET_LOW);
    localparam logic [CNT_W-1:0]       HIGH_MIN_C   = CNT_W'(HIGH_MIN);
    localparam logic [CNT_W-1:0]       HIGH_ONE_C   = CNT_W'(HIGH_ONE_MIN);
    localparam logic [CNT_W-1:0]       HIGH_MAX_C   = CNT_W'(HIGH_MAX);
    localparam logic [BUFFER_BITS-1:0] BUF_END_C    = BUFFER_BITS'(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0] BUF_ONE      = BUFFER_BITS'(1);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, s_q, s_prev_q;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [BUFFER_BITS-1:0] byte_cnt_q, byte_cnt_d;
    logic                   full_q, full_d;
    logic [7:0]             data_byte_q, data_byte_d;
    logic [BUFFER_BITS-1:0] byte_index_q, byte_index_d;
    logic                   data_valid_q, data_valid_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;
    logic                   ovf_q, ovf_d;

    logic                   rise, fall;
    logic [CNT_W-1:0]       high_inc, low_inc;
    logic [7:0]             shifted;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign rise     = s_q & ~s_prev_q;
    assign fall     = ~s_q & s_prev_q;
    assign high_inc = sat_inc(high_cnt_q);
    assign low_inc  = sat_inc(low_cnt_q);
    assign shifted  = {shift_q[6:0], (high_cnt_q >= HIGH_ONE_C)};

    always_comb begin
        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        full_d       = full_q;
        data_byte_d  = data_byte_q;
        byte_index_d = byte_index_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        err_d        = err_q;
        ovf_d        = ovf_q;

        case (state_q)
            SYNC: begin
                if (s_q) begin
                    low_cnt_d = '0;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc == RESET_LOW_C) state_d = IDLE;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d      = HIGH;
                    high_cnt_d   = CNT_ONE;
                    bit_cnt_d    = '0;
                    shift_d      = '0;
                    byte_cnt_d   = '0;
                    full_d       = 1'b0;
                    byte_index_d = '0;
                    err_d        = 1'b0;
                    ovf_d        = 1'b0;
                end
            end
            HIGH: begin
                if (s_q) begin
                    high_cnt_d = high_inc;
                    if (high_inc > HIGH_MAX_C) begin
                        err_d     = 1'b1;
                        state_d   = SYNC;
                        low_cnt_d = '0;
                    end
                end else if (fall) begin
                    if (high_cnt_q < HIGH_MIN_C) begin
                        err_d     = 1'b1;
                        state_d   = SYNC;
                        low_cnt_d = '0;
                    end else begin
                        shift_d   = shifted;
                        low_cnt_d = CNT_ONE;
                        state_d   = LOW;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            // Once index BUFFER_END has been emitted, further bytes only flag overflow.
                            if (full_q) begin
                                ovf_d = 1'b1;
                            end else begin
                                data_byte_d  = shifted;
                                data_valid_d = 1'b1;
                                byte_index_d = byte_cnt_q;
                                if (byte_cnt_q == BUF_END_C) full_d = 1'b1;
                                else byte_cnt_d = byte_cnt_q + BUF_ONE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d    = HIGH;
                    high_cnt_d = CNT_ONE;
                end else begin
                    low_cnt_d = low_inc;
                    if (low_inc == RESET_LOW_C) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        if (bit_cnt_q != 3'd0) err_d = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase

        // Disable overrides everything except the sticky flags and last byte/index.
        if (!enable) begin
            state_d      = SYNC;
            low_cnt_d    = '0;
            bit_cnt_d    = '0;
            shift_d      = '0;
            data_byte_d  = data_byte_q;
            byte_index_d = byte_index_q;
            data_valid_d = 1'b0;
            frame_done_d = 1'b0;
            err_d        = err_q;
            ovf_d        = ovf_q;
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (syncReset) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            s_prev_q     <= 1'b0;
            state_q      <= SYNC;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            full_q       <= 1'b0;
            data_byte_q  <= '0;
            byte_index_q <= '0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync1_q      <= neoDataIn;
            s_q          <= sync1_q;
            s_prev_q     <= s_q;
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            full_q       <= full_d;
            data_byte_q  <= data_byte_d;
            byte_index_q <= byte_index_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
        end
    end

    assign dataByte    = data_byte_q;
    assign dataValid   = data_valid_q;
    assign byteIndex   = byte_index_q;
    assign frameDone   = frame_done_q;
    assign decodeError = err_q;
    assign overflow    = ovf_q;

endmodule
